// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the "111" serial pattern detector.
//   state_e   : FSM state encoding (S0/S1/S2). The bench imports this package too.
//   S_ILLEGAL : the one unused 2-bit code, listed so recovery from it is explicit.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,  // no 1 seen
    S1 = 2'b01,  // one 1 seen
    S2 = 2'b10   // two or more consecutive 1s seen
  } state_e;

  localparam logic [1:0] S_ILLEGAL = 2'b11;

endpackage

// File: rtl/seq_det_111.sv
// seq_det_111: Mealy FSM that flags every "111" run on a serial input.
// Overlapping detection is supported, so a long run of 1s flags once per cycle.
//   clk   in  1  sole clock, rising edge
//   rst   in  1  asynchronous reset, active low
//   din   in  1  serial data bit, sampled on each rising clk edge
//   dout  out 1  combinational flag: state is S2 and din is 1
//   state out 2  state register, exposed directly for observability
module seq_det_111
  import seq_det_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       dout,
  output logic [1:0] state
);

  state_e state_q;
  state_e state_d;

  // Any 0 breaks the run; S2 saturates on further 1s so overlaps are caught.
  // The default arm also sends the unused 2'b11 code back to S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = din ? S1 : S0;
      S1:      state_d = din ? S2 : S0;
      S2:      state_d = din ? S2 : S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S0;
    else      state_q <= state_d;
  end

  // Mealy output: the third 1 is flagged while it is still on din,
  // before the edge that samples it.
  assign dout  = (state_q == S2) && din;
  assign state = state_q;

endmodule

// File: tb/tb_seq_det_111.sv
// tb_seq_det_111: directed and random checks of seq_det_111 against a run-length
// reference model (count of consecutive 1s seen so far).
module tb_seq_det_111;
  import seq_det_pkg::*;

  logic       clk;
  logic       rst;
  logic       din;
  logic       dout;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int run    = 0;   // model: consecutive 1s sampled since last 0 or reset

  seq_det_111 dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .dout  (dout),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_state(input int r);
    if (r == 0)      return S0;
    else if (r == 1) return S1;
    else             return S2;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
  endtask

  task automatic check_model(input string tag, input logic d);
    check({tag, "_state"}, state, exp_state(run));
    check({tag, "_dout"}, {1'b0, dout}, {1'b0, (run >= 2) && d});
  endtask

  // Called just after a rising edge: drive din, check mid-cycle, optionally
  // pulse async reset between edges, then advance the model across the edge.
  task automatic step(input string tag, input logic d, input bit rst_pulse);
    din = d;
    @(negedge clk);
    check_model(tag, d);
    if (rst_pulse) begin
      #1 rst = 1'b0;
      #1;
      run = 0;
      check({tag, "_arst_state"}, state, S0);
      check({tag, "_arst_dout"}, {1'b0, dout}, 2'b00);
      #1 rst = 1'b1;
    end
    @(posedge clk);
    run = d ? run + 1 : 0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_async_state", state, S0);
    check("rst_async_dout", {1'b0, dout}, 2'b00);
    din = 1'b1;
    #1;
    check("rst_din1_dout", {1'b0, dout}, 2'b00);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_state", state, S0);
      check("rst_hold_dout", {1'b0, dout}, 2'b00);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    run = 0;
    step("post_rst", 1'b0, 1'b0);
    step("post_rst", 1'b0, 1'b0);

    // held 1s: 00,01,10,10,...
    for (int i = 0; i < 6; i++) step("hold1", 1'b1, 1'b0);
    step("hold1_break", 1'b0, 1'b0);
    check("hold1_back_s0", state, S0);

    // 1,1,0,1,1,1
    step("s110111", 1'b1, 1'b0);
    step("s110111", 1'b1, 1'b0);
    step("s110111", 1'b0, 1'b0);
    check("s110111_zero_s0", state, S0);
    step("s110111", 1'b1, 1'b0);
    step("s110111", 1'b1, 1'b0);
    din = 1'b1;
    #1 check("s110111_sixth", {1'b0, dout}, 2'b01);
    step("s110111", 1'b1, 1'b0);
    step("gap", 1'b0, 1'b0);

    // overlap 1,1,1,1,1 then async reset while in S2 with din=1
    for (int i = 0; i < 5; i++) step("overlap", 1'b1, 1'b0);
    step("arst_mid", 1'b1, 1'b1);
    step("after_arst", 1'b1, 1'b0);
    step("after_arst", 1'b1, 1'b0);
    step("gap", 1'b0, 1'b0);

    // alternating 1,0 never detects
    for (int i = 0; i < 10; i++) step("alt", (i % 2) == 0, 1'b0);

    // random stream with occasional async reset pulses
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom_range(0, 31) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
